// File: rtl/lsu_v2.sv
// rtl/lsu_v2.sv - load/store unit: registered valid/ready memory port with optional timeout
module lsu_v2 #(
  parameter int          DATA_BITS          = 8,
  parameter int          ADDR_BITS          = 8,
  parameter int          TIMEOUT_CYCLES     = 0,
  parameter logic [2:0]  CORE_STATE_REQUEST = 3'b011,
  parameter logic [2:0]  CORE_STATE_UPDATE  = 3'b110
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_addr,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_addr,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic [1:0]           lsu_state,
  output logic                 lsu_error
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REQUESTING = 2'd1,
    WAITING    = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t                state, state_n;
  logic                  op_read;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [DATA_BITS-1:0]  data_q;
  logic [CW-1:0]         cnt;
  logic                  start, ready_act, timeout_hit;

  always_comb begin
    state_n     = state;
    start       = enable && (core_state == CORE_STATE_REQUEST) &&
                  (decoded_mem_read_enable || decoded_mem_write_enable);
    ready_act   = op_read ? mem_read_ready : mem_write_ready;
    // Abort on the edge where the count of ready-less WAITING cycles would reach the limit.
    timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt == CNT_LAST);
    case (state)
      IDLE:       if (start) state_n = REQUESTING;
      REQUESTING: state_n = WAITING;
      WAITING:    if (ready_act || timeout_hit) state_n = DONE;
      DONE:       if (core_state == CORE_STATE_UPDATE) state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_read         <= 1'b0;
      addr_q          <= '0;
      data_q          <= '0;
      cnt             <= '0;
      mem_read_valid  <= 1'b0;
      mem_read_addr   <= '0;
      mem_write_valid <= 1'b0;
      mem_write_addr  <= '0;
      mem_write_data  <= '0;
      lsu_out         <= '0;
      lsu_error       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          // Load wins when both flags are set; the store is silently dropped.
          op_read   <= decoded_mem_read_enable;
          addr_q    <= ADDR_BITS'(rs);
          data_q    <= rt;
          lsu_error <= 1'b0;
        end
        REQUESTING: begin
          cnt <= '0;
          if (op_read) begin
            mem_read_valid <= 1'b1;
            mem_read_addr  <= addr_q;
          end else begin
            mem_write_valid <= 1'b1;
            mem_write_addr  <= addr_q;
            mem_write_data  <= data_q;
          end
        end
        WAITING: begin
          if (ready_act) begin
            mem_read_valid  <= 1'b0;
            mem_write_valid <= 1'b0;
            if (op_read) lsu_out <= mem_read_data;
          end else if (timeout_hit) begin
            mem_read_valid  <= 1'b0;
            mem_write_valid <= 1'b0;
            lsu_error       <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign lsu_state = state;

endmodule

// File: tb/tb_lsu_v2.sv
// tb/tb_lsu_v2.sv - self-checking bench for lsu_v2 with a transaction-level reference model
module tb_lsu_v2;

  localparam int DB = 16;
  localparam int AB = 8;
  localparam int TO = 4;
  localparam logic [2:0] CS_REQ = 3'b011;
  localparam logic [2:0] CS_UPD = 3'b110;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [2:0]    core_state;
  logic          rd_en, wr_en;
  logic [DB-1:0] rs, rt;
  logic          mem_read_valid, mem_read_ready;
  logic [AB-1:0] mem_read_addr;
  logic [DB-1:0] mem_read_data;
  logic          mem_write_valid, mem_write_ready;
  logic [AB-1:0] mem_write_addr;
  logic [DB-1:0] mem_write_data;
  logic [DB-1:0] lsu_out;
  logic [1:0]    lsu_state;
  logic          lsu_error;

  int checks = 0;
  int errors = 0;
  logic [DB-1:0] model_out = '0;

  lsu_v2 #(
    .DATA_BITS(DB), .ADDR_BITS(AB), .TIMEOUT_CYCLES(TO),
    .CORE_STATE_REQUEST(CS_REQ), .CORE_STATE_UPDATE(CS_UPD)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
    .rs(rs), .rt(rt),
    .mem_read_valid(mem_read_valid), .mem_read_addr(mem_read_addr),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .lsu_out(lsu_out), .lsu_state(lsu_state), .lsu_error(lsu_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(lsu_state), 32'd0);
    check({tag, "_outs"}, {mem_read_valid, mem_write_valid, lsu_error},
          32'd0);
    check({tag, "_bus"}, 32'(mem_read_addr) | 32'(mem_write_addr) | 32'(mem_write_data), 32'd0);
    check({tag, "_lsu_out"}, 32'(lsu_out), 32'd0);
  endtask

  // dly = WAITING cycles before ready is sampled (ready seen at edge E1+dly); 0 = never ready.
  task automatic txn(input bit rd, input bit wr, input logic [DB-1:0] a,
                     input logic [DB-1:0] wd, input int dly, input logic [DB-1:0] rdata);
    bit is_rd;
    bit completes;
    int exp_cyc;
    int vcount;
    bit done_seen;
    is_rd     = rd;
    completes = (dly >= 1) && (dly <= TO);
    exp_cyc   = completes ? dly : TO;
    if (completes && is_rd) model_out = rdata;

    @(negedge clk);
    enable = 1'b1; core_state = CS_REQ; rd_en = rd; wr_en = wr; rs = a; rt = wd;
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0; core_state = 3'($urandom_range(0, 2));
    rs = DB'($urandom); rt = DB'($urandom); enable = 1'($urandom);
    check("start_state", 32'(lsu_state), 32'd1);
    check("start_error_cleared", 32'(lsu_error), 32'd0);
    check("start_no_valid", {mem_read_valid, mem_write_valid}, 32'd0);
    // Early ready before valid must be ignored.
    mem_read_ready = 1'($urandom); mem_write_ready = 1'($urandom);
    mem_read_data = DB'($urandom);

    vcount = 0; done_seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (lsu_state == 2'd3) begin done_seen = 1'b1; break; end
      if (is_rd) begin
        if (mem_read_valid) begin
          vcount++;
          check("rd_addr", 32'(mem_read_addr), 32'(a[AB-1:0]));
        end
        check("rd_no_wvalid", 32'(mem_write_valid), 32'd0);
        mem_read_ready  = (k == dly);
        mem_write_ready = 1'($urandom);
        mem_read_data   = (k == dly) ? rdata : DB'($urandom);
      end else begin
        if (mem_write_valid) begin
          vcount++;
          check("wr_addr", 32'(mem_write_addr), 32'(a[AB-1:0]));
          check("wr_data", 32'(mem_write_data), 32'(wd));
        end
        check("wr_no_rvalid", 32'(mem_read_valid), 32'd0);
        mem_write_ready = (k == dly);
        mem_read_ready  = 1'($urandom);
        mem_read_data   = DB'($urandom);
      end
      core_state = 3'($urandom_range(0, 5));
    end
    mem_read_ready = 1'b0; mem_write_ready = 1'b0;
    check("reached_done", 32'(done_seen), 32'd1);
    check("valid_cycles", 32'(vcount), 32'(exp_cyc));
    check("done_valids_low", {mem_read_valid, mem_write_valid}, 32'd0);
    check("error_flag", 32'(lsu_error), 32'(!completes));
    check("lsu_out", 32'(lsu_out), 32'(model_out));
    for (int h = 0; h < 2; h++) begin
      core_state = 3'($urandom_range(0, 5));
      @(negedge clk);
      check("done_hold", 32'(lsu_state), 32'd3);
      check("done_hold_out", 32'(lsu_out), 32'(model_out));
    end
    core_state = CS_UPD;
    @(negedge clk);
    check("back_idle", 32'(lsu_state), 32'd0);
    core_state = 3'd0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; core_state = 3'd0; rd_en = 1'b0; wr_en = 1'b0;
    rs = '0; rt = '0; mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    txn(1'b1, 1'b0, 16'h002A, 16'h0000, 4, 16'h005C);
    txn(1'b0, 1'b1, 16'h0010, 16'h00AB, 1, 16'h0000);
    txn(1'b1, 1'b1, 16'h0007, 16'h00EE, 2, 16'h1357);
    txn(1'b1, 1'b0, 16'h0044, 16'h0000, 0, 16'hFFFF);
    txn(1'b0, 1'b1, 16'h1234, 16'hBEEF, 3, 16'h0000);
    txn(1'b0, 1'b1, 16'h0099, 16'h0101, 0, 16'h0000);

    // enable low or non-memory instruction in REQUEST state: stay idle.
    @(negedge clk);
    enable = 1'b0; core_state = CS_REQ; rd_en = 1'b1; rs = 16'h0055;
    repeat (3) begin
      @(negedge clk);
      check("disabled_idle", 32'(lsu_state), 32'd0);
      check("disabled_no_valid", {mem_read_valid, mem_write_valid}, 32'd0);
    end
    enable = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("nonmem_idle", 32'(lsu_state), 32'd0);
    end
    core_state = 3'd0;

    for (int n = 0; n < 20; n++) begin
      logic [1:0] fl;
      fl = 2'($urandom_range(1, 3));
      txn(fl[0], fl[1], DB'($urandom), DB'($urandom), $urandom_range(0, 6), DB'($urandom));
    end

    // Reset while WAITING with valid high.
    @(negedge clk);
    enable = 1'b1; core_state = CS_REQ; rd_en = 1'b1; rs = 16'h0066;
    @(negedge clk);
    rd_en = 1'b0; core_state = 3'd0;
    @(negedge clk);
    check("pre_reset_valid", 32'(mem_read_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("reset_in_wait");
    mem_read_ready = 1'b1; mem_read_data = 16'hCAFE;
    @(negedge clk);
    mem_read_ready = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset_ready");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
